// File: rtl/spi_slave_responder.sv
// spi_slave_responder
//   SPI mode-0 slave used as the far end of the uart2spi SPI master link in loopback and
//   self-test builds. The block receives MSB-first bytes on mosi and returns bytes from a
//   one-entry tx holding register on miso. sck, cs_n and mosi are asynchronous and are
//   oversampled by i_clk, which must run at least 8x the sck rate.
//
// Optional feature macro: SPI_SLAVE_RX_FIFO_EN
//   undefined : rx storage is a single register
//   defined   : rx storage is an RX_FIFO_DEPTH-entry FIFO (power of 2, at least 2)
//
// Ports
//   i_clk       system clock, all logic on the rising edge
//   i_reset     synchronous active-high reset
//   i_sck       SPI clock from master (async)
//   i_cs_n      SPI chip select, active low (async)
//   i_mosi      SPI data master->slave (async)
//   o_miso      SPI data slave->master
//   o_miso_oe   miso output enable, high only while selected
//   i_tx_data   byte to return to the master
//   i_tx_valid  i_tx_data valid
//   o_tx_ready  holding register empty; load on i_tx_valid & o_tx_ready
//   o_rx_data   received byte
//   o_rx_valid  o_rx_data valid, held until accepted
//   i_rx_ready  consumer accepts on o_rx_valid & i_rx_ready
//   o_overrun   1-cycle pulse: received byte dropped, no rx storage free
//   o_underrun  1-cycle pulse: DEFAULT_TX sent because the holding register was empty
module spi_slave_responder #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter logic [7:0]  DEFAULT_TX    = 8'hFF,
    parameter int unsigned RX_FIFO_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_sck,
    input  logic       i_cs_n,
    input  logic       i_mosi,
    output logic       o_miso,
    output logic       o_miso_oe,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic       i_rx_ready,
    output logic       o_overrun,
    output logic       o_underrun
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;

    // ------------------------------------------------------------------
    // Input synchronizers plus one history flop for edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_hist;
    logic                   r_cs_hist;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sck_sync  <= '0;
            // Deselected after reset so no phantom frame start is seen.
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_hist  <= 1'b0;
            r_cs_hist   <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sck_hist  <= r_sck_sync[SYNC_STAGES-1];
            r_cs_hist   <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    logic w_sck_s;
    logic w_cs_s;
    logic w_mosi_s;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_cs_rise;
    logic w_cs_fall;

    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck_s & ~r_sck_hist;
    assign w_sck_fall = ~w_sck_s & r_sck_hist;
    assign w_cs_rise  = w_cs_s & ~r_cs_hist;
    assign w_cs_fall  = ~w_cs_s & r_cs_hist;

    // ------------------------------------------------------------------
    // Shift engine FSM
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift_tx;   // bits still to be driven after the current miso bit
    logic [6:0] r_shift_rx;   // first seven bits of the byte being received
    logic       r_miso;
    logic       r_miso_oe;
    logic       r_underrun;

    logic [7:0] r_tx_hold;
    logic       r_tx_full;

    logic       w_reload;
    logic [7:0] w_tx_next;
    logic       w_rx_push;
    logic [7:0] w_rx_byte;
    logic       w_rx_pop;

    // A falling sck with bit_cnt==0 in ACTIVE means the 8th bit has just been sampled, so the
    // next byte is fetched; in mode 0 the first edge of a frame is always a rising one.
    assign w_reload  = ~w_cs_rise &
                       ((r_state == S_LOAD) ||
                        ((r_state == S_ACTIVE) && w_sck_fall && (r_bit_cnt == 3'd0)));
    assign w_tx_next = r_tx_full ? r_tx_hold : DEFAULT_TX;
    assign w_rx_push = ~w_cs_rise && (r_state == S_ACTIVE) && w_sck_rise && (r_bit_cnt == 3'd7);
    assign w_rx_byte = {r_shift_rx, w_mosi_s};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 3'd0;
            r_shift_tx <= 7'd0;
            r_shift_rx <= 7'd0;
            r_miso     <= 1'b0;
            r_miso_oe  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_cs_rise) begin
                // Deselect from any state: partial rx byte and in-flight tx byte are dropped.
                r_state   <= S_IDLE;
                r_bit_cnt <= 3'd0;
                r_miso    <= 1'b0;
                r_miso_oe <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_cs_fall) begin
                            r_state   <= S_LOAD;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    S_LOAD: begin
                        r_state <= S_ACTIVE;
                    end
                    S_ACTIVE: begin
                        if (w_sck_rise) begin
                            r_shift_rx <= {r_shift_rx[5:0], w_mosi_s};
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                        end else if (w_sck_fall && (r_bit_cnt != 3'd0)) begin
                            r_miso     <= r_shift_tx[6];
                            r_shift_tx <= {r_shift_tx[5:0], 1'b0};
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
                if (w_reload) begin
                    r_miso     <= w_tx_next[7];
                    r_shift_tx <= w_tx_next[6:0];
                    r_miso_oe  <= 1'b1;
                    r_underrun <= ~r_tx_full;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // tx holding register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_hold <= 8'd0;
            r_tx_full <= 1'b0;
        end else if (w_reload && r_tx_full) begin
            r_tx_full <= 1'b0;
        end else if (i_tx_valid && !r_tx_full) begin
            r_tx_hold <= i_tx_data;
            r_tx_full <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // rx storage
    // ------------------------------------------------------------------
    logic r_overrun;

    assign w_rx_pop = o_rx_valid & i_rx_ready;

`ifdef SPI_SLAVE_RX_FIFO_EN
    localparam int unsigned AW = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;

    logic [7:0] r_fifo [RX_FIFO_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        w_empty;
    logic        w_full;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_overrun <= 1'b0;
            for (int i = 0; i < RX_FIFO_DEPTH; i++) begin
                r_fifo[i] <= 8'd0;
            end
        end else begin
            r_overrun <= 1'b0;
            if (w_rx_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            // A pop in the same cycle frees the slot, so a push at full still succeeds.
            if (w_rx_push) begin
                if (w_full && !w_rx_pop) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_fifo[r_wptr[AW-1:0]] <= w_rx_byte;
                    r_wptr                 <= r_wptr + 1'b1;
                end
            end
        end
    end

    assign o_rx_data  = r_fifo[r_rptr[AW-1:0]];
    assign o_rx_valid = ~w_empty;
`else
    logic [7:0] r_rx_data;
    logic       r_rx_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_rx_push) begin
                if (r_rx_valid && !i_rx_ready) begin
                    r_overrun <= 1'b1;
                end else begin
                    // Old byte (if any) is accepted this cycle, new one takes its place.
                    r_rx_data  <= w_rx_byte;
                    r_rx_valid <= 1'b1;
                end
            end else if (w_rx_pop) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;
`endif

    assign o_miso     = r_miso;
    assign o_miso_oe  = r_miso_oe;
    assign o_tx_ready = ~r_tx_full;
    assign o_overrun  = r_overrun;
    assign o_underrun = r_underrun;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: drives a mode-0 SPI master (sck half period of
// 8 clk cycles) and checks miso data, rx/tx handshakes and the overrun/underrun pulses.
module tb_spi_slave_responder;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       sck      = 1'b0;
    logic       cs_n     = 1'b1;
    logic       mosi     = 1'b0;
    logic [7:0] tx_data  = 8'd0;
    logic       tx_valid = 1'b0;
    logic       rx_ready = 1'b0;

    logic       w_miso;
    logic       w_miso_oe;
    logic       w_tx_ready;
    logic [7:0] w_rx_data;
    logic       w_rx_valid;
    logic       w_overrun;
    logic       w_underrun;

    int n_checks = 0;
    int n_fail   = 0;
    int n_under  = 0;
    int n_over   = 0;

    spi_slave_responder dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_sck      (sck),
        .i_cs_n     (cs_n),
        .i_mosi     (mosi),
        .o_miso     (w_miso),
        .o_miso_oe  (w_miso_oe),
        .i_tx_data  (tx_data),
        .i_tx_valid (tx_valid),
        .o_tx_ready (w_tx_ready),
        .o_rx_data  (w_rx_data),
        .o_rx_valid (w_rx_valid),
        .i_rx_ready (rx_ready),
        .o_overrun  (w_overrun),
        .o_underrun (w_underrun)
    );

    always #5 clk = ~clk;

    // Pulse counters; the main sequence compares deltas around each scenario.
    always @(posedge clk) begin
        if (w_underrun) n_under <= n_under + 1;
        if (w_overrun)  n_over  <= n_over + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One mode-0 bit: mosi changes with sck low, miso sampled just before the rising edge.
    // sck is left high; the next bit (or cs_high) brings it low.
    task automatic spi_bit(input logic b, output logic m);
        sck  = 1'b0;
        mosi = b;
        wait_clks(8);
        m    = w_miso;
        sck  = 1'b1;
        wait_clks(8);
    endtask

    task automatic spi_byte(input logic [7:0] mo, output logic [7:0] mi);
        logic m;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(mo[i], m);
            mi[i] = m;
        end
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        wait_clks(8);
    endtask

    // Final sck fall coincides with deselect, so no next-byte fetch happens.
    task automatic cs_high();
        sck  = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        wait_clks(16);
    endtask

    task automatic push_tx(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        wait_clks(1);
        tx_valid = 1'b0;
    endtask

    task automatic pop_rx();
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_miso"},     w_miso,     1'b0);
        check({tag, "_miso_oe"},  w_miso_oe,  1'b0);
        check({tag, "_tx_ready"}, w_tx_ready, 1'b1);
        check({tag, "_rx_valid"}, w_rx_valid, 1'b0);
        check({tag, "_rx_data"},  w_rx_data,  8'h00);
        check({tag, "_overrun"},  w_overrun,  1'b0);
        check({tag, "_underrun"}, w_underrun, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] mi;
        logic       m;
        int         u0;
        int         o0;

        // 1: reset values, then sck toggling with cs_n high does nothing
        wait_clks(3);
        check_reset_values("rst");
        reset = 1'b0;
        wait_clks(2);
        for (int p = 0; p < 4; p++) begin
            sck = 1'b1;
            wait_clks(8);
            check("idle_oe_hi", w_miso_oe, 1'b0);
            check("idle_rxv_hi", w_rx_valid, 1'b0);
            check("idle_txr_hi", w_tx_ready, 1'b1);
            sck = 1'b0;
            wait_clks(8);
            check("idle_oe_lo", w_miso_oe, 1'b0);
            check("idle_rxv_lo", w_rx_valid, 1'b0);
            check("idle_txr_lo", w_tx_ready, 1'b1);
        end
        check("idle_underruns", n_under, 0);

        // 2: holding A5, master sends 3C
        push_tx(8'hA5);
        check("t2_tx_ready_after_load", w_tx_ready, 1'b0);
        u0 = n_under;
        cs_low();
        check("t2_oe_selected", w_miso_oe, 1'b1);
        spi_byte(8'h3C, mi);
        cs_high();
        check("t2_miso_byte", mi, 8'hA5);
        check("t2_rx_data", w_rx_data, 8'h3C);
        check("t2_rx_valid", w_rx_valid, 1'b1);
        check("t2_tx_ready", w_tx_ready, 1'b1);
        check("t2_underruns", n_under - u0, 0);
        check("t2_oe_deselected", w_miso_oe, 1'b0);
        pop_rx();
        check("t2_rx_valid_popped", w_rx_valid, 1'b0);

        // 3: empty holding register -> DEFAULT_TX and a single underrun
        u0 = n_under;
        cs_low();
        spi_byte(8'h00, mi);
        cs_high();
        check("t3_miso_byte", mi, 8'hFF);
        check("t3_underruns", n_under - u0, 1);
        check("t3_rx_data", w_rx_data, 8'h00);
        check("t3_rx_valid", w_rx_valid, 1'b1);
        pop_rx();

        // 4: three back-to-back bytes with rx_ready low
        u0 = n_under;
        o0 = n_over;
        cs_low();
        spi_byte(8'h11, mi);
        check("t4_miso0", mi, 8'hFF);
        spi_byte(8'h22, mi);
        check("t4_miso1", mi, 8'hFF);
        spi_byte(8'h33, mi);
        check("t4_miso2", mi, 8'hFF);
        cs_high();
        check("t4_underruns", n_under - u0, 3);
`ifdef SPI_SLAVE_RX_FIFO_EN
        check("t4_overruns", n_over - o0, 0);
        check("t4_rx_valid0", w_rx_valid, 1'b1);
        check("t4_rx_data0", w_rx_data, 8'h11);
        pop_rx();
        check("t4_rx_valid1", w_rx_valid, 1'b1);
        check("t4_rx_data1", w_rx_data, 8'h22);
        pop_rx();
        check("t4_rx_valid2", w_rx_valid, 1'b1);
        check("t4_rx_data2", w_rx_data, 8'h33);
        pop_rx();
`else
        check("t4_overruns", n_over - o0, 2);
        check("t4_rx_valid", w_rx_valid, 1'b1);
        check("t4_rx_data", w_rx_data, 8'h11);
        pop_rx();
`endif
        check("t4_rx_empty", w_rx_valid, 1'b0);

        // 5: abort after 5 bits, then a clean 81
        cs_low();
        for (int i = 0; i < 5; i++) begin
            spi_bit(1'b1, m);
        end
        cs_high();
        check("t5_partial_rx_valid", w_rx_valid, 1'b0);
        check("t5_partial_oe", w_miso_oe, 1'b0);
        cs_low();
        spi_byte(8'h81, mi);
        cs_high();
        check("t5_rx_data", w_rx_data, 8'h81);
        check("t5_rx_valid", w_rx_valid, 1'b1);

        // 6: reset in the middle of a byte, with a byte pending in the holding register
        push_tx(8'h5A);
        cs_low();
        for (int i = 0; i < 3; i++) begin
            spi_bit(1'b1, m);
        end
        push_tx(8'h77);
        check("t6_tx_ready_pending", w_tx_ready, 1'b0);
        check("t6_oe_midframe", w_miso_oe, 1'b1);
        reset = 1'b1;
        cs_n  = 1'b1;
        sck   = 1'b0;
        @(posedge clk);
        #1;
        check_reset_values("t6_rst");
        @(negedge clk);
        reset = 1'b0;
        wait_clks(4);
        check("t6_oe_after_reset", w_miso_oe, 1'b0);
        push_tx(8'hC3);
        cs_low();
        spi_byte(8'h96, mi);
        cs_high();
        check("t6_miso_byte", mi, 8'hC3);
        check("t6_rx_data", w_rx_data, 8'h96);
        check("t6_rx_valid", w_rx_valid, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
